mem_access_unit: RTL and testbench

//  Parametrised successor to the single-cycle data-memory stage. Serves word loads/stores from the

---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit_data_ram.sv | 24 ++
 rtl/mem_access_unit.sv | 107 ++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access stage: FSM encoding, word geometry,
// latched request payload and request validation.
package mem_access_unit_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_XFER = 2'd2
  } ms_state_t;

  typedef struct packed {
    logic              is_st;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Reject misaligned, out-of-range, or simultaneous load+store requests.
  function automatic logic req_fault(input logic [31:0] offset, input logic ld,
                                     input logic st, input int unsigned depth);
    logic misaligned;
    logic out_of_range;
    misaligned   = (offset & 32'(WORD_BYTES - 1)) != 32'd0;
    out_of_range = (offset >> 2) >= 32'(depth);
    return misaligned || out_of_range || (ld && st);
  endfunction

endpackage

// File: rtl/mem_access_unit_data_ram.sv
// Single-port synchronous RAM with write enable and registered read (read-first).
module data_ram
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: validates word load/store requests, inserts programmable wait
// states while holding memBusy, then performs a one-cycle transfer against data_ram.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isLd,
  input  logic        isSt,
  input  logic [31:0] aluResult,
  input  logic [31:0] op2,
  output logic [31:0] ldResult,
  output logic        ldValid,
  output logic        memBusy,
  output logic        memFault
);

  localparam int unsigned AW = $clog2(DEPTH);

  ms_state_t             state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [AW-1:0]         idx_q;
  mem_req_t              req_q;

  logic [31:0]       offset;
  logic              req;
  logic              fault;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign offset  = aluResult - BASE_ADDR;
  assign req     = isLd | isSt;
  assign fault   = req_fault(offset, isLd, isSt, DEPTH);
  assign memBusy = (state != MS_IDLE);

  // The RAM read is launched from the live request in IDLE (needed for zero wait
  // states) and from the latched index afterwards, so rdata is ready in XFER.
  assign ram_addr = (state == MS_IDLE) ? offset[AW+1:2] : idx_q;
  // A store whose XFER edge coincides with reset must not land in the RAM.
  assign ram_we   = (state == MS_XFER) && req_q.is_st && !reset;

  data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MS_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      req_q    <= '0;
      ldResult <= '0;
      ldValid  <= 1'b0;
      memFault <= 1'b0;
    end else begin
      ldValid  <= 1'b0;
      memFault <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (req) begin
            if (fault) begin
              memFault <= 1'b1;
            end else begin
              idx_q       <= offset[AW+1:2];
              req_q.is_st <= isSt;
              req_q.wdata <= op2;
              if (WAIT_STATES > 0) begin
                state    <= MS_WAIT;
                wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
              end else begin
                state <= MS_XFER;
              end
            end
          end
        end
        MS_WAIT: begin
          if (wait_cnt == '0) begin
            state <= MS_XFER;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
        MS_XFER: begin
          if (!req_q.is_st) begin
            ldResult <= ram_rdata;
            ldValid  <= 1'b1;
          end
          state <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// checked against an associative-array memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        isLd, isSt;
  logic [31:0] aluResult, op2, ldResult;
  logic        ldValid, memBusy, memFault;

  logic        isLd_z, isSt_z;
  logic [31:0] aluResult_z, op2_z, ldResult_z;
  logic        ldValid_z, memBusy_z, memFault_z;

  mem_access_unit #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .reset(reset), .isLd(isLd), .isSt(isSt), .aluResult(aluResult), .op2(op2),
    .ldResult(ldResult), .ldValid(ldValid), .memBusy(memBusy), .memFault(memFault));

  mem_access_unit #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .reset(reset), .isLd(isLd_z), .isSt(isSt_z), .aluResult(aluResult_z),
    .op2(op2_z), .ldResult(ldResult_z), .ldValid(ldValid_z), .memBusy(memBusy_z),
    .memFault(memFault_z));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_model [int];
  logic [31:0] exp_ld;
  localparam int WS = 2;

  function automatic bit exp_fault(input bit ld, input bit st, input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= 1024) || (ld && st);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then wait out the busy window; returns what was observed.
  task automatic access(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] data, output int busy, output bit flt,
                        output bit vld, output logic [31:0] res);
    isLd = ld; isSt = st; aluResult = addr; op2 = data;
    tick();
    isLd = 0; isSt = 0;
    flt = memFault;
    busy = 0;
    while (memBusy && busy < 50) begin
      busy++;
      tick();
    end
    vld = ldValid;
    res = ldResult;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++; if (ldResult !== 32'h0) begin errors++; $display("FAIL reset_ldResult got %h exp 0", ldResult); end
    checks++; if ({ldValid, memBusy, memFault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ldValid, memBusy, memFault}); end
    checks++; if ({ldValid_z, memBusy_z, memFault_z, ldResult_z} !== 35'h0) begin errors++; $display("FAIL reset_z got %b/%h exp 0", {ldValid_z, memBusy_z, memFault_z}, ldResult_z); end
    exp_ld = 32'h0;
  endtask

  task automatic test_store_load();
    int b; bit f, v; logic [31:0] r;
    access(0, 1, 32'h20, 32'hCAFEBABE, b, f, v, r);
    mem_model[8] = 32'hCAFEBABE;
    checks++; if (b !== WS + 1) begin errors++; $display("FAIL st_busy got %0d exp %0d", b, WS + 1); end
    checks++; if ({f, v} !== 2'b00) begin errors++; $display("FAIL st_flags got %b exp 00", {f, v}); end
    access(1, 0, 32'h20, 32'h0, b, f, v, r);
    exp_ld = 32'hCAFEBABE;
    checks++; if (b !== WS + 1) begin errors++; $display("FAIL ld_busy got %0d exp %0d", b, WS + 1); end
    checks++; if (v !== 1'b1 || r !== exp_ld) begin errors++; $display("FAIL ld_data got v=%b %h exp v=1 %h", v, r, exp_ld); end
    tick();
    checks++; if (ldValid !== 1'b0) begin errors++; $display("FAIL ld_pulse got %b exp 0", ldValid); end
  endtask

  task automatic test_fault();
    int b; bit f, v; logic [31:0] r;
    logic [31:0] addrs [3] = '{32'h22, 32'h1000, 32'hFFFF_FFFC};
    foreach (addrs[i]) begin
      access(1, 0, addrs[i], 32'h0, b, f, v, r);
      checks++; if (f !== 1'b1 || b !== 0) begin errors++; $display("FAIL fault_%0d got f=%b busy=%0d exp f=1 busy=0", i, f, b); end
      checks++; if (r !== exp_ld || v !== 1'b0) begin errors++; $display("FAIL fault_hold_%0d got %h v=%b exp %h v=0", i, r, v, exp_ld); end
      tick();
      checks++; if (memFault !== 1'b0) begin errors++; $display("FAIL fault_pulse_%0d got %b exp 0", i, memFault); end
    end
  endtask

  task automatic test_busy_drop();
    int b; bit f, v, saw_fault; logic [31:0] r;
    access(0, 1, 32'h44, 32'h44444444, b, f, v, r);
    mem_model[17] = 32'h44444444;
    isSt = 1; aluResult = 32'h40; op2 = 32'h11111111;
    tick();
    aluResult = 32'h44; op2 = 32'h22222222;
    b = 0; saw_fault = 0;
    while (memBusy && b < 50) begin
      b++; saw_fault |= memFault; tick();
    end
    isSt = 0;
    mem_model[16] = 32'h11111111;
    checks++; if (b !== WS + 1 || saw_fault !== 1'b0) begin errors++; $display("FAIL drop_busy got %0d f=%b exp %0d f=0", b, saw_fault, WS + 1); end
    access(1, 0, 32'h40, 32'h0, b, f, v, r);
    checks++; if (r !== mem_model[16]) begin errors++; $display("FAIL drop_40 got %h exp %h", r, mem_model[16]); end
    access(1, 0, 32'h44, 32'h0, b, f, v, r);
    exp_ld = mem_model[17];
    checks++; if (r !== exp_ld) begin errors++; $display("FAIL drop_44 got %h exp %h", r, exp_ld); end
  endtask

  task automatic test_both();
    int b; bit f, v; logic [31:0] r;
    access(0, 1, 32'h08, 32'hA5A5A5A5, b, f, v, r);
    mem_model[2] = 32'hA5A5A5A5;
    access(1, 1, 32'h08, 32'h0, b, f, v, r);
    checks++; if (f !== 1'b1 || b !== 0) begin errors++; $display("FAIL both_fault got f=%b busy=%0d exp f=1 busy=0", f, b); end
    access(1, 0, 32'h08, 32'h0, b, f, v, r);
    exp_ld = mem_model[2];
    checks++; if (r !== exp_ld) begin errors++; $display("FAIL both_ram got %h exp %h", r, exp_ld); end
  endtask

  task automatic test_zero_wait();
    isSt_z = 1; aluResult_z = 32'h30; op2_z = 32'h0BADF00D;
    tick();
    isSt_z = 0;
    checks++; if (memBusy_z !== 1'b1 || ldValid_z !== 1'b0) begin errors++; $display("FAIL z_st_busy got b=%b v=%b exp 1 0", memBusy_z, ldValid_z); end
    tick();
    checks++; if (memBusy_z !== 1'b0) begin errors++; $display("FAIL z_st_done got %b exp 0", memBusy_z); end
    isLd_z = 1;
    tick();
    isLd_z = 0;
    checks++; if (memBusy_z !== 1'b1 || ldValid_z !== 1'b0) begin errors++; $display("FAIL z_ld_busy got b=%b v=%b exp 1 0", memBusy_z, ldValid_z); end
    tick();
    checks++; if (ldValid_z !== 1'b1 || ldResult_z !== 32'h0BADF00D || memBusy_z !== 1'b0) begin errors++; $display("FAIL z_ld got v=%b %h exp v=1 0badf00d", ldValid_z, ldResult_z); end
  endtask

  task automatic test_reset_abort();
    int b; bit f, v; logic [31:0] r;
    access(0, 1, 32'h10, 32'h12345678, b, f, v, r);
    access(0, 1, 32'h14, 32'h55555555, b, f, v, r);
    mem_model[4] = 32'h12345678;
    mem_model[5] = 32'h55555555;
    isSt = 1; aluResult = 32'h10; op2 = 32'hDEADBEEF;
    tick();
    isSt = 0;
    reset = 1;
    tick();
    reset = 0;
    exp_ld = 32'h0;
    checks++; if ({memBusy, ldValid, memFault} !== 3'b000 || ldResult !== 32'h0) begin errors++; $display("FAIL abort_state got %b %h exp 000 0", {memBusy, ldValid, memFault}, ldResult); end
    isSt = 1; aluResult = 32'h14; op2 = 32'h66666666;
    tick();
    isSt = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    access(1, 0, 32'h10, 32'h0, b, f, v, r);
    checks++; if (r !== mem_model[4]) begin errors++; $display("FAIL abort_10 got %h exp %h", r, mem_model[4]); end
    access(1, 0, 32'h14, 32'h0, b, f, v, r);
    exp_ld = mem_model[5];
    checks++; if (r !== exp_ld) begin errors++; $display("FAIL abort_xfer got %h exp %h", r, exp_ld); end
  endtask

  task automatic test_back_to_back();
    int b, start, bad_busy; bit f, v; logic [31:0] r;
    bad_busy = 0;
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d = $urandom;
      access(0, 1, 32'(i * 4), d, b, f, v, r);
      mem_model[i] = d;
      if (b != WS + 1) bad_busy++;
    end
    for (int i = 0; i < 16; i++) begin
      access(1, 0, 32'(i * 4), 32'h0, b, f, v, r);
      if (b != WS + 1) bad_busy++;
      checks++; if (v !== 1'b1 || r !== mem_model[i]) begin errors++; $display("FAIL b2b_word%0d got v=%b %h exp %h", i, v, r, mem_model[i]); end
    end
    exp_ld = mem_model[15];
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL b2b_busy got %0d bad exp 0", bad_busy); end
    checks++; if (cyc - start !== 32 * (WS + 2)) begin errors++; $display("FAIL b2b_cycles got %0d exp %0d", cyc - start, 32 * (WS + 2)); end
  endtask

  task automatic test_random();
    int b, kind, idx; bit f, v, ld, st, ef; logic [31:0] r, addr, d;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 63);
      d    = $urandom;
      addr = 32'(idx * 4);
      ld = mem_model.exists(idx) ? 1'($urandom_range(0, 1)) : 1'b0;
      st = !ld;
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'h1000 + 32'($urandom_range(0, 1000) * 4);
      else if (kind == 2) begin ld = 1; st = 1; end
      ef = exp_fault(ld, st, addr);
      access(ld, st, addr, d, b, f, v, r);
      if (!ef && st) mem_model[idx] = d;
      if (!ef && ld) exp_ld = mem_model[idx];
      checks++; if (f !== ef || b !== (ef ? 0 : WS + 1)) begin errors++; $display("FAIL rnd%0d_ctl got f=%b busy=%0d exp f=%b", n, f, b, ef); end
      checks++; if (r !== exp_ld || v !== (ld && !ef)) begin errors++; $display("FAIL rnd%0d_data got %h v=%b exp %h", n, r, v, exp_ld); end
    end
  endtask

  initial begin
    reset = 1; isLd = 0; isSt = 0; aluResult = 0; op2 = 0;
    isLd_z = 0; isSt_z = 0; aluResult_z = 0; op2_z = 0;
    test_reset();
    test_store_load();
    test_fault();
    test_busy_drop();
    test_both();
    test_zero_wait();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
